// File: rtl/scb_arbiter_if.sv
// scb_arbiter_if: requester and scratchpad signal bundle for the SCB arbiter
//   req/we/addr/wdata/be   per-port request, held until the matching gnt bit is seen
//   gnt                    per-port combinational accept
//   rvalid/rdata           per-port read return, one cycle after a read grant
//   scb_*                  shared scratchpad port (addr, wdata, stb, ce, rd, wr, rdata, rdy)
//   slave modport: the arbiter; master modport: the requesters plus the scratchpad
interface scb_arbiter_if;
   logic [1:0]        req;
   logic [1:0]        we;
   logic [1:0][10:0]  addr;
   logic [1:0][15:0]  wdata;
   logic [1:0][1:0]   be;
   logic [1:0]        gnt;
   logic [1:0]        rvalid;
   logic [1:0][15:0]  rdata;
   logic [10:0]       scb_addr;
   logic [15:0]       scb_wdata;
   logic [1:0]        scb_stb;
   logic              scb_ce;
   logic              scb_rd;
   logic              scb_wr;
   logic [15:0]       scb_rdata;
   logic              scb_rdy;
   modport slave (
      input  req, we, addr, wdata, be, scb_rdata, scb_rdy,
      output gnt, rvalid, rdata, scb_addr, scb_wdata, scb_stb, scb_ce, scb_rd, scb_wr
   );
   modport master (
      output req, we, addr, wdata, be, scb_rdata, scb_rdy,
      input  gnt, rvalid, rdata, scb_addr, scb_wdata, scb_stb, scb_ce, scb_rd, scb_wr
   );
endinterface

// File: rtl/scb_arbiter.sv
// scb_arbiter: two-port (CPU=0, DMA=1) arbiter for the 1024x16 SCB scratchpad
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-low reset
//   bus     scb_arbiter_if.slave: per-port req/we/addr/wdata/be in, gnt/rvalid/rdata out,
//           shared scratchpad port scb_addr/wdata/stb/ce/rd/wr out, scb_rdata/scb_rdy in
//   FIXED_PRIO  0 = round-robin, 1 = port 0 priority with anti-starvation for port 1
//   STARVE_MAX  consecutive denied cycles after which port 1 is forced (FIXED_PRIO=1)
module scb_arbiter #(
   parameter bit FIXED_PRIO = 1'b0,
   parameter int STARVE_MAX = 4
) (
   input logic          clk_i,
   input logic          rst_i,
   scb_arbiter_if.slave bus
);
   localparam int CW = $clog2(STARVE_MAX + 1);
   typedef enum logic {IDLE, DATA} state_t;
   state_t         state, state_nx;
   logic [1:0]     elig, rv;
   logic           win, any, rd_gnt, held_hi, rr_last, starved;
   logic [10:0]    addr_q;
   logic [CW-1:0]  starve_cnt;
   // During a read data phase the scratchpad output mux follows the live address,
   // so only requests to the same half as the outstanding read may be issued.
   always_comb begin
      elig = '0;
      for (int n = 0; n < 2; n++)
         elig[n] = rst_i & bus.req[n] & bus.scb_rdy & (state == IDLE || bus.addr[n][10] == held_hi);
   end
   assign starved = starve_cnt == CW'(STARVE_MAX);
   assign any     = |elig;
   assign win     = &elig ? (FIXED_PRIO ? starved : ~rr_last) : elig[1];
   assign rd_gnt  = bus.scb_ce & ~bus.we[win];
   always_comb begin
      state_nx = IDLE;
      state_nx = rd_gnt ? DATA : IDLE;
   end
   assign bus.gnt       = {any & win, any & ~win};
   assign bus.scb_ce    = any & (|bus.be[win]);
   assign bus.scb_rd    = bus.scb_ce & ~bus.we[win];
   assign bus.scb_wr    = bus.scb_ce & bus.we[win];
   // Address is held from the last grant so the half-select stays put through a data phase.
   assign bus.scb_addr  = any ? bus.addr[win] : addr_q;
   assign bus.scb_wdata = any ? bus.wdata[win] : '0;
   assign bus.scb_stb   = any ? bus.be[win] : '0;
   assign bus.rvalid    = rv;
   assign bus.rdata     = {rv[1] ? bus.scb_rdata : 16'h0, rv[0] ? bus.scb_rdata : 16'h0};
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state      <= IDLE;
         held_hi    <= 1'b0;
         rr_last    <= 1'b1;
         addr_q     <= '0;
         rv         <= '0;
         starve_cnt <= '0;
      end else begin
         state      <= state_nx;
         held_hi    <= rd_gnt ? bus.addr[win][10] : held_hi;
         rr_last    <= any ? win : rr_last;
         addr_q     <= bus.scb_addr;
         rv         <= {rd_gnt & win, rd_gnt & ~win};
         starve_cnt <= (!FIXED_PRIO || !bus.req[1] || bus.gnt[1]) ? '0 :
                       starved ? starve_cnt : starve_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_scb_arbiter.sv
// tb_scb_arbiter: directed and randomized checks of scb_arbiter against a behavioural model
module tb_scb_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_checks = 0;
   int n_fail = 0;
   logic [15:0] sp_mem [1024];
   logic [15:0] ref_mem [1024];
   logic [15:0] sp_lo = '0;
   logic [15:0] sp_hi = '0;
   scb_arbiter_if bus_rr();
   scb_arbiter_if bus_fp();
   scb_arbiter #(.FIXED_PRIO(1'b0), .STARVE_MAX(4)) u_rr (.clk_i(clk), .rst_i(rst_n), .bus(bus_rr.slave));
   scb_arbiter #(.FIXED_PRIO(1'b1), .STARVE_MAX(4)) u_fp (.clk_i(clk), .rst_i(rst_n), .bus(bus_fp.slave));
   always #5 clk = ~clk;
   // Scratchpad: both halves latched on a read ce, output mux decodes the live address bit 10.
   always @(posedge clk) begin
      if (bus_rr.scb_ce && bus_rr.scb_wr) begin
         if (bus_rr.scb_stb[0]) sp_mem[bus_rr.scb_addr[10:1]][7:0] <= bus_rr.scb_wdata[7:0];
         if (bus_rr.scb_stb[1]) sp_mem[bus_rr.scb_addr[10:1]][15:8] <= bus_rr.scb_wdata[15:8];
      end
      if (bus_rr.scb_ce && bus_rr.scb_rd) begin
         sp_lo <= sp_mem[{1'b0, bus_rr.scb_addr[9:1]}];
         sp_hi <= sp_mem[{1'b1, bus_rr.scb_addr[9:1]}];
      end
   end
   assign bus_rr.scb_rdata = bus_rr.scb_addr[10] ? sp_hi : sp_lo;
   assign bus_fp.scb_rdata = 16'hA5A5;

   task automatic idle_all();
      bus_rr.req = '0;
      bus_fp.req = '0;
   endtask

   task automatic drive(input int p, input logic we, input logic [10:0] a, input logic [15:0] d, input logic [1:0] be);
      bus_rr.req[p] = 1'b1;
      bus_rr.we[p] = we;
      bus_rr.addr[p] = a;
      bus_rr.wdata[p] = d;
      bus_rr.be[p] = be;
   endtask

   task automatic do_reset();
      idle_all();
      bus_rr.we = '0; bus_rr.addr = '0; bus_rr.wdata = '0; bus_rr.be = '0; bus_rr.scb_rdy = 1'b1;
      bus_fp.we = '0; bus_fp.addr = '0; bus_fp.wdata = '0; bus_fp.be = '0; bus_fp.scb_rdy = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      drive(0, 1'b0, 11'h010, 16'h0, 2'b11);
      drive(1, 1'b1, 11'h012, 16'h1234, 2'b11);
      bus_fp.req = 2'b11; bus_fp.be = '1;
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++; if (bus_rr.gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got=%b exp=00", bus_rr.gnt); end
      n_checks++; if (bus_fp.gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt_fp got=%b exp=00", bus_fp.gnt); end
      n_checks++; if (bus_rr.rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got=%b exp=00", bus_rr.rvalid); end
      n_checks++; if (bus_rr.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", bus_rr.rdata); end
      n_checks++; if ({bus_rr.scb_ce, bus_rr.scb_rd, bus_rr.scb_wr, bus_rr.scb_stb} !== 5'b0) begin n_fail++; $display("FAIL reset_ctl got=%b%b%b%b exp=00000", bus_rr.scb_ce, bus_rr.scb_rd, bus_rr.scb_wr, bus_rr.scb_stb); end
      n_checks++; if (bus_rr.scb_addr !== 11'h0 || bus_rr.scb_wdata !== 16'h0) begin n_fail++; $display("FAIL reset_bus got=%h/%h exp=0/0", bus_rr.scb_addr, bus_rr.scb_wdata); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle_all();
   endtask

   task automatic test_single_read();
      do_reset();
      drive(0, 1'b0, 11'h010, 16'h0, 2'b11);
      @(negedge clk);
      n_checks++; if (bus_rr.gnt !== 2'b01) begin n_fail++; $display("FAIL rd_gnt got=%b exp=01", bus_rr.gnt); end
      n_checks++; if ({bus_rr.scb_ce, bus_rr.scb_rd, bus_rr.scb_wr} !== 3'b110) begin n_fail++; $display("FAIL rd_ctl got=%b%b%b exp=110", bus_rr.scb_ce, bus_rr.scb_rd, bus_rr.scb_wr); end
      n_checks++; if (bus_rr.scb_addr !== 11'h010) begin n_fail++; $display("FAIL rd_addr got=%h exp=010", bus_rr.scb_addr); end
      @(posedge clk);
      #1 idle_all();
      @(negedge clk);
      n_checks++; if (bus_rr.rvalid !== 2'b01) begin n_fail++; $display("FAIL rd_rvalid got=%b exp=01", bus_rr.rvalid); end
      n_checks++; if (bus_rr.rdata[0] !== 16'hBEEF) begin n_fail++; $display("FAIL rd_rdata got=%h exp=beef", bus_rr.rdata[0]); end
      n_checks++; if (bus_rr.scb_ce !== 1'b0) begin n_fail++; $display("FAIL rd_ce_once got=%b exp=0", bus_rr.scb_ce); end
      @(negedge clk);
      n_checks++; if (bus_rr.rvalid !== 2'b00) begin n_fail++; $display("FAIL rd_rvalid_end got=%b exp=00", bus_rr.rvalid); end
   endtask

   task automatic test_rr();
      logic [10:0] a0, a1, pa;
      logic [1:0] eg, prev;
      do_reset();
      a0 = 11'h100; a1 = 11'h200; prev = 2'b00; pa = '0;
      for (int c = 0; c < 8; c++) begin
         drive(0, 1'b0, a0, 16'h0, 2'b11);
         drive(1, 1'b0, a1, 16'h0, 2'b11);
         eg = (c % 2 == 0) ? 2'b01 : 2'b10;
         @(negedge clk);
         n_checks++; if (bus_rr.gnt !== eg) begin n_fail++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, bus_rr.gnt, eg); end
         n_checks++; if (bus_rr.scb_ce !== 1'b1) begin n_fail++; $display("FAIL rr_ce c=%0d got=%b exp=1", c, bus_rr.scb_ce); end
         n_checks++; if (bus_rr.rvalid !== prev) begin n_fail++; $display("FAIL rr_rvalid c=%0d got=%b exp=%b", c, bus_rr.rvalid, prev); end
         if (prev != 2'b00) begin
            n_checks++; if (bus_rr.rdata[prev[1]] !== ref_mem[pa[10:1]]) begin n_fail++; $display("FAIL rr_rdata c=%0d got=%h exp=%h", c, bus_rr.rdata[prev[1]], ref_mem[pa[10:1]]); end
         end
         prev = eg;
         pa = eg[1] ? a1 : a0;
         @(posedge clk);
         #1;
         if (eg[0]) a0 = a0 + 11'd4; else a1 = a1 + 11'd4;
      end
      idle_all();
      @(posedge clk);
      #1;
   endtask

   task automatic test_half_stall();
      do_reset();
      drive(0, 1'b0, 11'h004, 16'h0, 2'b11);
      @(negedge clk);
      n_checks++; if (bus_rr.gnt !== 2'b01) begin n_fail++; $display("FAIL hs_gnt0 got=%b exp=01", bus_rr.gnt); end
      @(posedge clk);
      #1 idle_all();
      drive(1, 1'b0, 11'h404, 16'h0, 2'b11);
      @(negedge clk);
      n_checks++; if (bus_rr.gnt !== 2'b00) begin n_fail++; $display("FAIL hs_stall got=%b exp=00", bus_rr.gnt); end
      n_checks++; if (bus_rr.scb_addr[10] !== 1'b0) begin n_fail++; $display("FAIL hs_half got=%b exp=0", bus_rr.scb_addr[10]); end
      n_checks++; if (bus_rr.rvalid !== 2'b01 || bus_rr.rdata[0] !== ref_mem[10'h002]) begin n_fail++; $display("FAIL hs_rdata0 got=%b/%h exp=01/%h", bus_rr.rvalid, bus_rr.rdata[0], ref_mem[10'h002]); end
      @(negedge clk);
      n_checks++; if (bus_rr.gnt !== 2'b10 || bus_rr.scb_addr !== 11'h404) begin n_fail++; $display("FAIL hs_gnt1 got=%b/%h exp=10/404", bus_rr.gnt, bus_rr.scb_addr); end
      @(posedge clk);
      #1 idle_all();
      @(negedge clk);
      n_checks++; if (bus_rr.rvalid !== 2'b10 || bus_rr.rdata[1] !== ref_mem[10'h202]) begin n_fail++; $display("FAIL hs_rdata1 got=%b/%h exp=10/%h", bus_rr.rvalid, bus_rr.rdata[1], ref_mem[10'h202]); end
   endtask

   task automatic test_write_readback();
      logic [15:0] expw;
      do_reset();
      expw = {8'h12, ref_mem[10'h011][7:0]};
      drive(0, 1'b1, 11'h022, 16'h12AB, 2'b10);
      @(negedge clk);
      n_checks++; if (bus_rr.gnt !== 2'b01 || {bus_rr.scb_ce, bus_rr.scb_rd, bus_rr.scb_wr} !== 3'b101) begin n_fail++; $display("FAIL wr_ctl got=%b %b%b%b exp=01 101", bus_rr.gnt, bus_rr.scb_ce, bus_rr.scb_rd, bus_rr.scb_wr); end
      n_checks++; if (bus_rr.scb_stb !== 2'b10 || bus_rr.scb_wdata !== 16'h12AB || bus_rr.scb_addr !== 11'h022) begin n_fail++; $display("FAIL wr_bus got=%b/%h/%h exp=10/12ab/022", bus_rr.scb_stb, bus_rr.scb_wdata, bus_rr.scb_addr); end
      @(posedge clk);
      ref_mem[10'h011][15:8] = 8'h12;
      #1 drive(0, 1'b0, 11'h022, 16'h0, 2'b11);
      @(negedge clk);
      n_checks++; if (bus_rr.gnt !== 2'b01 || bus_rr.rvalid !== 2'b00) begin n_fail++; $display("FAIL wr_nores got=%b/%b exp=01/00", bus_rr.gnt, bus_rr.rvalid); end
      @(posedge clk);
      #1 idle_all();
      @(negedge clk);
      n_checks++; if (bus_rr.rvalid !== 2'b01 || bus_rr.rdata[0] !== expw) begin n_fail++; $display("FAIL wr_readback got=%b/%h exp=01/%h", bus_rr.rvalid, bus_rr.rdata[0], expw); end
   endtask

   task automatic test_be_zero();
      do_reset();
      drive(1, 1'b0, 11'h030, 16'h0, 2'b00);
      @(negedge clk);
      n_checks++; if (bus_rr.gnt !== 2'b10 || bus_rr.scb_ce !== 1'b0 || bus_rr.scb_rd !== 1'b0) begin n_fail++; $display("FAIL be0_rd got=%b/%b%b exp=10/00", bus_rr.gnt, bus_rr.scb_ce, bus_rr.scb_rd); end
      @(posedge clk);
      #1 idle_all();
      drive(0, 1'b1, 11'h032, 16'h5555, 2'b00);
      @(negedge clk);
      n_checks++; if (bus_rr.rvalid !== 2'b00) begin n_fail++; $display("FAIL be0_rvalid got=%b exp=00", bus_rr.rvalid); end
      n_checks++; if (bus_rr.gnt !== 2'b01 || bus_rr.scb_ce !== 1'b0 || bus_rr.scb_wr !== 1'b0) begin n_fail++; $display("FAIL be0_wr got=%b/%b%b exp=01/00", bus_rr.gnt, bus_rr.scb_ce, bus_rr.scb_wr); end
      @(posedge clk);
      #1 idle_all();
   endtask

   task automatic test_starve();
      logic [1:0] eg;
      do_reset();
      bus_fp.be = 4'b1111; bus_fp.addr = {11'h002, 11'h000}; bus_fp.req = 2'b11;
      for (int c = 0; c < 10; c++) begin
         eg = (c % 5 == 4) ? 2'b10 : 2'b01;
         @(negedge clk);
         n_checks++; if (bus_fp.gnt !== eg) begin n_fail++; $display("FAIL starve_gnt c=%0d got=%b exp=%b", c, bus_fp.gnt, eg); end
         @(posedge clk);
         #1;
      end
      // Three denials, a one-cycle drop, then a full fresh count is needed again.
      for (int c = 0; c < 9; c++) begin
         bus_fp.req[1] = (c != 3);
         eg = (c == 8) ? 2'b10 : 2'b01;
         @(negedge clk);
         n_checks++; if (bus_fp.gnt !== eg) begin n_fail++; $display("FAIL starve_drop c=%0d got=%b exp=%b", c, bus_fp.gnt, eg); end
         @(posedge clk);
         #1;
      end
      idle_all();
   endtask

   task automatic test_reset_in_data();
      do_reset();
      drive(0, 1'b0, 11'h010, 16'h0, 2'b11);
      @(negedge clk);
      n_checks++; if (bus_rr.gnt !== 2'b01) begin n_fail++; $display("FAIL rid_gnt got=%b exp=01", bus_rr.gnt); end
      @(posedge clk);
      #1 rst_n = 1'b0;
      bus_rr.scb_rdy = 1'b0;
      drive(1, 1'b0, 11'h012, 16'h0, 2'b11);
      @(negedge clk);
      n_checks++; if (bus_rr.rvalid !== 2'b00 || bus_rr.gnt !== 2'b00 || bus_rr.scb_addr !== 11'h0) begin n_fail++; $display("FAIL rid_reset got=%b/%b/%h exp=00/00/000", bus_rr.rvalid, bus_rr.gnt, bus_rr.scb_addr); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++; if (bus_rr.gnt !== 2'b00 || bus_rr.rvalid !== 2'b00 || bus_rr.scb_ce !== 1'b0 || bus_rr.rdata !== 32'h0 || bus_rr.scb_addr !== 11'h0) begin n_fail++; $display("FAIL rid_rdylow c=%0d got=%b/%b/%b/%h/%h exp=00/00/0/0/000", c, bus_rr.gnt, bus_rr.rvalid, bus_rr.scb_ce, bus_rr.rdata, bus_rr.scb_addr); end
      end
      @(posedge clk);
      #1 bus_rr.scb_rdy = 1'b1;
      @(negedge clk);
      n_checks++; if (bus_rr.gnt !== 2'b01) begin n_fail++; $display("FAIL rid_first_tie got=%b exp=01", bus_rr.gnt); end
      @(posedge clk);
      #1 idle_all();
   endtask

   task automatic test_random();
      bit e [2];
      bit m_pend, m_hi, issue;
      int m_last, m_port, w;
      logic [15:0] m_data, mask;
      logic [1:0] m_be, eg;
      logic [9:0] idx;
      do_reset();
      m_pend = 1'b0; m_hi = 1'b0; m_last = 1; m_port = 0; m_data = '0; m_be = '0;
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < 2; p++)
            if (!bus_rr.req[p] && $urandom_range(0, 2) != 0)
               drive(p, 1'($urandom_range(0, 1)), 11'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
         bus_rr.scb_rdy = ($urandom_range(0, 5) != 0);
         @(negedge clk);
         for (int p = 0; p < 2; p++)
            e[p] = bus_rr.req[p] && bus_rr.scb_rdy && (!m_pend || bus_rr.addr[p][10] == m_hi);
         w = (e[0] && e[1]) ? (m_last == 0 ? 1 : 0) : e[1] ? 1 : e[0] ? 0 : -1;
         eg = (w < 0) ? 2'b00 : (w == 1) ? 2'b10 : 2'b01;
         issue = (w >= 0) && (bus_rr.be[w] != 2'b00);
         n_checks++; if (bus_rr.gnt !== eg) begin n_fail++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, bus_rr.gnt, eg); end
         n_checks++; if (bus_rr.scb_ce !== issue) begin n_fail++; $display("FAIL rnd_ce c=%0d got=%b exp=%b", c, bus_rr.scb_ce, issue); end
         if (issue) begin
            n_checks++; if (bus_rr.scb_addr !== bus_rr.addr[w] || bus_rr.scb_stb !== bus_rr.be[w] || bus_rr.scb_wr !== bus_rr.we[w] || bus_rr.scb_rd !== !bus_rr.we[w]) begin n_fail++; $display("FAIL rnd_issue c=%0d got=%h/%b/%b%b exp=%h/%b/we=%b", c, bus_rr.scb_addr, bus_rr.scb_stb, bus_rr.scb_rd, bus_rr.scb_wr, bus_rr.addr[w], bus_rr.be[w], bus_rr.we[w]); end
            if (bus_rr.we[w]) begin
               n_checks++; if (bus_rr.scb_wdata !== bus_rr.wdata[w]) begin n_fail++; $display("FAIL rnd_wdata c=%0d got=%h exp=%h", c, bus_rr.scb_wdata, bus_rr.wdata[w]); end
            end
         end
         n_checks++; if (bus_rr.rvalid !== (m_pend ? (m_port == 1 ? 2'b10 : 2'b01) : 2'b00)) begin n_fail++; $display("FAIL rnd_rvalid c=%0d got=%b exp=pend%0d port%0d", c, bus_rr.rvalid, m_pend, m_port); end
         if (m_pend) begin
            mask = {{8{m_be[1]}}, {8{m_be[0]}}};
            n_checks++; if ((bus_rr.rdata[m_port] & mask) !== (m_data & mask) || bus_rr.rdata[1 - m_port] !== 16'h0) begin n_fail++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h mask=%h", c, bus_rr.rdata[m_port], m_data, mask); end
         end
         @(posedge clk);
         if (w >= 0) m_last = w;
         m_pend = 1'b0;
         if (issue) begin
            idx = bus_rr.addr[w][10:1];
            if (bus_rr.we[w]) begin
               if (bus_rr.be[w][0]) ref_mem[idx][7:0] = bus_rr.wdata[w][7:0];
               if (bus_rr.be[w][1]) ref_mem[idx][15:8] = bus_rr.wdata[w][15:8];
            end else begin
               m_pend = 1'b1; m_hi = bus_rr.addr[w][10]; m_port = w; m_data = ref_mem[idx]; m_be = bus_rr.be[w];
            end
         end
         #1;
         if (w >= 0) bus_rr.req[w] = 1'b0;
      end
      idle_all();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         sp_mem[i] = 16'(i * 40503) ^ 16'h5A5A;
         ref_mem[i] = 16'(i * 40503) ^ 16'h5A5A;
      end
      sp_mem[8] = 16'hBEEF;
      ref_mem[8] = 16'hBEEF;
      test_reset();
      test_single_read();
      test_rr();
      test_half_stall();
      test_write_readback();
      test_be_zero();
      test_starve();
      test_reset_in_data();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end
endmodule
